// File: rtl/instr_fetch_if.sv
// instr_fetch_if: control, test-load and IF/ID bundle between the fetch stage and its neighbours.
interface instr_fetch_if #(parameter int AW = 8);
    logic          pc_write;
    logic          if_id_write;
    logic          branch_taken;
    logic [31:0]   branch_target;
    logic          imem_we;
    logic [AW-1:0] imem_waddr;
    logic [31:0]   imem_wdata;
    logic [31:0]   pc;
    logic [31:0]   if_id_instr;
    logic [31:0]   if_id_pc;
    logic          if_id_valid;
    logic          halted;
    logic          fetch_fault;
    modport master (
        output pc_write, if_id_write, branch_taken, branch_target, imem_we, imem_waddr, imem_wdata,
        input  pc, if_id_instr, if_id_pc, if_id_valid, halted, fetch_fault
    );
    modport slave (
        input  pc_write, if_id_write, branch_taken, branch_target, imem_we, imem_waddr, imem_wdata,
        output pc, if_id_instr, if_id_pc, if_id_valid, halted, fetch_fault
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: PC, word-addressed instruction memory and IF/ID register with stall,
// redirect, sticky halt on EXIT and sticky fault on out-of-range or misaligned PCs.
module instr_fetch_unit #(
    parameter int          IMEM_DEPTH = 256,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter logic [31:0] HALT_INSTR = 32'hFFFF_FFFF,
    parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    instr_fetch_if.slave bus
);
    localparam int AW = $clog2(IMEM_DEPTH);

    typedef enum logic [1:0] {S_RUN, S_HALT, S_FAULT} state_e;

    state_e      state_q, state_d;
    logic [31:0] mem [IMEM_DEPTH];
    logic [31:0] pc_q, pc_d, instr_q, instr_d, ipc_q, ipc_d, fetch_word;
    logic        valid_q, valid_d, halted_q, halted_d, fault_q, fault_d;
    logic        fetch_ok, is_halt;

    always_ff @(posedge clk) begin
        if (bus.imem_we) mem[bus.imem_waddr] <= bus.imem_wdata;
    end

    assign fetch_ok   = pc_q[1:0] == 2'b00 && pc_q[31:AW+2] == '0;
    assign fetch_word = fetch_ok ? mem[pc_q[AW+1:2]] : NOP_INSTR;
    assign is_halt    = fetch_ok && fetch_word == HALT_INSTR;

    always_comb begin
        pc_d     = pc_q;
        instr_d  = instr_q;
        ipc_d    = ipc_q;
        valid_d  = valid_q;
        state_d  = state_q;
        halted_d = halted_q;
        fault_d  = fault_q;
        if (bus.branch_taken) begin
            pc_d     = bus.branch_target;
            instr_d  = NOP_INSTR;
            ipc_d    = pc_q;
            valid_d  = 1'b0;
            halted_d = 1'b0;
            state_d  = S_RUN;
        end else if (state_q != S_RUN) begin
            if (bus.if_id_write) begin
                instr_d = NOP_INSTR;
                ipc_d   = pc_q;
                valid_d = 1'b0;
            end
        end else begin
            if (bus.if_id_write) begin
                instr_d = fetch_word;
                ipc_d   = pc_q;
                valid_d = fetch_ok;
            end
            // a fault freezes the PC on the offending address regardless of pc_write
            if (!fetch_ok) begin
                state_d = S_FAULT;
                fault_d = 1'b1;
            end else if (bus.pc_write) begin
                pc_d     = is_halt ? pc_q : pc_q + 32'd4;
                halted_d = is_halt;
                state_d  = is_halt ? S_HALT : S_RUN;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_RUN;
            pc_q     <= RESET_PC;
            instr_q  <= NOP_INSTR;
            ipc_q    <= '0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            instr_q  <= instr_d;
            ipc_q    <= ipc_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
            fault_q  <= fault_d;
        end
    end

    assign bus.pc          = pc_q;
    assign bus.if_id_instr = instr_q;
    assign bus.if_id_pc    = ipc_q;
    assign bus.if_id_valid = valid_q;
    assign bus.halted      = halted_q;
    assign bus.fetch_fault = fault_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: directed test-plan scenarios followed by randomized traffic,
// every cycle compared against a behavioural fetch model.
module tb_instr_fetch_unit;
    localparam int          DEPTH = 256;
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] HALT  = 32'hFFFF_FFFF;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;

    instr_fetch_if #(.AW(8)) bus();
    instr_fetch_unit #(.IMEM_DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    logic [31:0] m_mem [DEPTH];
    logic [31:0] m_pc, m_instr, m_ipc;
    logic        m_valid, m_halted, m_fault, m_stopped;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic m_reset();
        m_pc = 32'h0; m_instr = NOP; m_ipc = 32'h0;
        m_valid = 1'b0; m_halted = 1'b0; m_fault = 1'b0; m_stopped = 1'b0;
    endtask

    task automatic m_edge();
        logic        good;
        logic [31:0] fw;
        if (!rst_n) m_reset();
        else begin
            good = (m_pc % 4 == 0) && (m_pc < 32'(4 * DEPTH));
            fw = good ? m_mem[(m_pc / 4) % DEPTH] : NOP;
            if (bus.branch_taken) begin
                m_ipc = m_pc; m_instr = NOP; m_valid = 1'b0;
                m_pc = bus.branch_target; m_halted = 1'b0; m_stopped = 1'b0;
            end else if (m_stopped) begin
                if (bus.if_id_write) begin m_ipc = m_pc; m_instr = NOP; m_valid = 1'b0; end
            end else begin
                if (bus.if_id_write) begin m_ipc = m_pc; m_instr = fw; m_valid = good; end
                if (!good) begin m_stopped = 1'b1; m_fault = 1'b1; end
                else if (bus.pc_write && fw == HALT) begin m_stopped = 1'b1; m_halted = 1'b1; end
                else if (bus.pc_write) m_pc = m_pc + 32'd4;
            end
        end
        if (bus.imem_we) m_mem[bus.imem_waddr] = bus.imem_wdata;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pc"}, bus.pc, m_pc);
        check({tag, ".instr"}, bus.if_id_instr, m_instr);
        check({tag, ".ipc"}, bus.if_id_pc, m_ipc);
        check({tag, ".valid"}, 32'(bus.if_id_valid), 32'(m_valid));
        check({tag, ".halted"}, 32'(bus.halted), 32'(m_halted));
        check({tag, ".fault"}, 32'(bus.fetch_fault), 32'(m_fault));
    endtask

    task automatic step();
        @(posedge clk);
        m_edge();
        @(negedge clk);
        check_all("cyc");
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, b, c, d, x, w;
        int          r;
        a = 32'h1111_0001; b = 32'h2222_0002; c = 32'h3333_0003;
        d = 32'h4444_0008; x = 32'hABCD_1234;
        bus.pc_write = 1'b1; bus.if_id_write = 1'b1; bus.branch_taken = 1'b0;
        bus.branch_target = 32'h0; bus.imem_we = 1'b0; bus.imem_waddr = 8'h0; bus.imem_wdata = 32'h0;
        m_reset();
        for (int i = 0; i < DEPTH; i++) begin
            w = $urandom;
            if (w == HALT) w = 32'h0;
            w = i == 0 ? a : i == 1 ? b : i == 2 ? c : i == 8 ? d : i == 10 ? HALT : w;
            @(negedge clk);
            bus.imem_we = 1'b1; bus.imem_waddr = 8'(i); bus.imem_wdata = w;
            step();
        end
        bus.imem_we = 1'b0;
        check("rst_pc", bus.pc, 32'h0);
        check("rst_instr", bus.if_id_instr, NOP);
        rst_n = 1'b1;
        step();
        check("seq_a", bus.if_id_instr, a);
        check("seq_pc0", bus.if_id_pc, 32'h0);
        bus.pc_write = 1'b0; bus.if_id_write = 1'b0;
        step(); step();
        check("stall_pc", bus.pc, 32'h4);
        check("stall_hold", bus.if_id_instr, a);
        bus.pc_write = 1'b1; bus.if_id_write = 1'b1;
        step();
        check("resume_b", bus.if_id_instr, b);
        bus.branch_taken = 1'b1; bus.branch_target = 32'h20;
        step();
        check("br_pc", bus.pc, 32'h20);
        check("br_bubble", 32'(bus.if_id_valid), 32'h0);
        bus.branch_taken = 1'b0;
        step();
        check("br_instr", bus.if_id_instr, d);
        check("br_ipc", bus.if_id_pc, 32'h20);
        step(); step();
        check("halt_flag", 32'(bus.halted), 32'h1);
        check("halt_instr", bus.if_id_instr, HALT);
        step();
        check("halt_pc", bus.pc, 32'h28);
        check("halt_bubble", 32'(bus.if_id_valid), 32'h0);
        bus.branch_taken = 1'b1; bus.branch_target = 32'h0;
        step();
        check("halt_clear", 32'(bus.halted), 32'h0);
        bus.branch_taken = 1'b0;
        step();
        check("refetch_a", bus.if_id_instr, a);
        bus.branch_taken = 1'b1; bus.branch_target = 32'h400;
        step();
        bus.branch_taken = 1'b0;
        step(); step();
        check("fault_range", 32'(bus.fetch_fault), 32'h1);
        check("fault_pc", bus.pc, 32'h400);
        bus.branch_taken = 1'b1; bus.branch_target = 32'h6;
        step();
        bus.branch_taken = 1'b0;
        step();
        check("fault_mis_pc", bus.pc, 32'h6);
        check("fault_sticky", 32'(bus.fetch_fault), 32'h1);
        #2 rst_n = 1'b0;
        #1 m_reset();
        check_all("arst");
        step();
        rst_n = 1'b1;
        step();
        bus.imem_we = 1'b1; bus.imem_waddr = 8'h1; bus.imem_wdata = x;
        step();
        check("coll_old", bus.if_id_instr, b);
        bus.imem_we = 1'b0; bus.branch_taken = 1'b1; bus.branch_target = 32'h4;
        step();
        bus.branch_taken = 1'b0;
        step();
        check("coll_new", bus.if_id_instr, x);
        for (int n = 0; n < 3000; n++) begin
            bus.pc_write = $urandom_range(0, 9) < 8;
            bus.if_id_write = $urandom_range(0, 9) < 8;
            bus.branch_taken = $urandom_range(0, 11) == 0;
            r = $urandom_range(0, 15);
            bus.branch_target = r < 13 ? {22'h0, 8'($urandom), 2'b00} :
                                r == 13 ? 32'h400 + {22'h0, 8'($urandom), 2'b00} : $urandom;
            bus.imem_we = $urandom_range(0, 7) == 0;
            bus.imem_waddr = 8'($urandom);
            bus.imem_wdata = $urandom_range(0, 15) == 0 ? HALT : $urandom;
            if ($urandom_range(0, 299) == 0) rst_n = 1'b0;
            step();
            rst_n = 1'b1;
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
